// File: rtl/regsel_seq.sv
// regsel_seq: micro-sequencer driving the regSel register-select decoder for
// multi-cycle MOV / ALU / SWAP register transfers. Operands are latched on
// start; each class then walks a fixed schedule of oe/load/ALU-strobe steps.
module regsel_seq #(
    parameter logic [2:0] TMP_REG = 3'd7
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       start,
    input  logic [1:0] opClass,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [2:0] op2,
    input  logic       stall,
    output logic       oe,
    output logic       load,
    output logic [1:0] oeSourceSel,
    output logic       loadSourceSel,
    output logic [2:0] useqRegSelOe,
    output logic [2:0] useqRegSelLoad,
    output logic [2:0] opOut0,
    output logic [2:0] opOut1,
    output logic [2:0] opOut2,
    output logic       aluALoad,
    output logic       aluBLoad,
    output logic       aluOe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // FIN_ERR is the FIN step of a reserved-class request; it differs from
    // FIN only in raising err.
    typedef enum logic [3:0] {
        IDLE,
        M1,
        A1,
        A2,
        A3,
        S1,
        S2,
        S3,
        FIN,
        FIN_ERR
    } state_t;

    typedef struct packed {
        logic       oe;
        logic [1:0] oe_sel;
        logic       load;
        logic       load_sel;
        logic [2:0] useq_oe;
        logic [2:0] useq_load;
        logic       alu_a;
        logic       alu_b;
        logic       alu_oe;
        logic       busy;
        logic       done;
        logic       err;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    // Moore decode of a state into its control word; src_a is the latched
    // op1 field, used as the load target of the last SWAP step.
    function automatic ctrl_t decode(input state_t s, input logic [2:0] src_a);
        ctrl_t c;
        c = '0;
        c.busy = (s != IDLE);
        case (s)
            M1: begin
                c.oe = 1'b1; c.oe_sel = 2'd2; c.load = 1'b1; c.load_sel = 1'b1;
            end
            A1: begin
                c.oe = 1'b1; c.oe_sel = 2'd2; c.alu_a = 1'b1;
            end
            A2: begin
                c.oe = 1'b1; c.oe_sel = 2'd3; c.alu_b = 1'b1;
            end
            A3: begin
                c.alu_oe = 1'b1; c.load = 1'b1; c.load_sel = 1'b1;
            end
            S1: begin
                c.oe = 1'b1; c.oe_sel = 2'd1; c.load = 1'b1; c.load_sel = 1'b0;
                c.useq_load = TMP_REG;
            end
            S2: begin
                c.oe = 1'b1; c.oe_sel = 2'd2; c.load = 1'b1; c.load_sel = 1'b1;
            end
            S3: begin
                c.oe = 1'b1; c.oe_sel = 2'd0; c.useq_oe = TMP_REG;
                c.load = 1'b1; c.load_sel = 1'b0; c.useq_load = src_a;
            end
            FIN: begin
                c.done = 1'b1;
            end
            FIN_ERR: begin
                c.done = 1'b1; c.err = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state: class dispatch from IDLE, stall holds transfer states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (opClass)
                        2'd0:    state_nxt = M1;
                        2'd1:    state_nxt = A1;
                        2'd2:    state_nxt = S1;
                        default: state_nxt = FIN_ERR;
                    endcase
                end
            end
            M1:      state_nxt = stall ? M1 : FIN;
            A1:      state_nxt = stall ? A1 : A2;
            A2:      state_nxt = stall ? A2 : A3;
            A3:      state_nxt = stall ? A3 : FIN;
            S1:      state_nxt = stall ? S1 : S2;
            S2:      state_nxt = stall ? S2 : S3;
            S3:      state_nxt = stall ? S3 : FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand latches and registered control word.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state  <= IDLE;
            ctrl   <= '0;
            opOut0 <= '0;
            opOut1 <= '0;
            opOut2 <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt, opOut1);
            if (state == IDLE && start) begin
                opOut0 <= op0;
                opOut1 <= op1;
                opOut2 <= op2;
            end
        end
    end

    // The control word is registered from the next state, so a stalled cycle
    // keeps the oe side; write strobes are masked combinationally by stall so
    // a held step never writes twice. IDLE/FIN carry no strobes, so the mask
    // has no effect there.
    always_comb begin
        oe             = ctrl.oe;
        oeSourceSel    = ctrl.oe_sel;
        load           = ctrl.load & ~stall;
        loadSourceSel  = ctrl.load_sel;
        useqRegSelOe   = ctrl.useq_oe;
        useqRegSelLoad = ctrl.useq_load;
        aluALoad       = ctrl.alu_a & ~stall;
        aluBLoad       = ctrl.alu_b & ~stall;
        aluOe          = ctrl.alu_oe;
        busy           = ctrl.busy;
        done           = ctrl.done;
        err            = ctrl.err;
    end

endmodule

// File: tb/tb_regsel_seq.sv
// Scoreboard bench for regsel_seq: stimulus pushes hand-computed output
// vectors for each busy cycle; a monitor pops and compares whenever busy=1.
module tb_regsel_seq;

    logic       clock;
    logic       notReset;
    logic       start;
    logic [1:0] opClass;
    logic [2:0] op0, op1, op2;
    logic       stall;
    logic       oe, load, loadSourceSel;
    logic [1:0] oeSourceSel;
    logic [2:0] useqRegSelOe, useqRegSelLoad, opOut0, opOut1, opOut2;
    logic       aluALoad, aluBLoad, aluOe, busy, done, err;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        string       name;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];

    regsel_seq #(.TMP_REG(3'd7)) dut (
        .clock(clock), .notReset(notReset), .start(start), .opClass(opClass),
        .op0(op0), .op1(op1), .op2(op2), .stall(stall),
        .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOe(useqRegSelOe), .useqRegSelLoad(useqRegSelLoad),
        .opOut0(opOut0), .opOut1(opOut1), .opOut2(opOut2),
        .aluALoad(aluALoad), .aluBLoad(aluBLoad), .aluOe(aluOe),
        .busy(busy), .done(done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector layout: busy done err oe oesel[2] load lsel uoe[3] uld[3] aa ab ao o0[3] o1[3] o2[3]
    function automatic logic [25:0] mk(
        input logic bsy, input logic dn, input logic er,
        input logic o, input logic [1:0] os, input logic l, input logic ls,
        input logic [2:0] uo, input logic [2:0] ul,
        input logic aa, input logic ab, input logic ao,
        input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2);
        return {bsy, dn, er, o, os, l, ls, uo, ul, aa, ab, ao, p0, p1, p2};
    endfunction

    function automatic logic [25:0] actual();
        return {busy, done, err, oe, oeSourceSel, load, loadSourceSel,
                useqRegSelOe, useqRegSelLoad, aluALoad, aluBLoad, aluOe,
                opOut0, opOut1, opOut2};
    endfunction

    task automatic push(input string name, input logic [25:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Monitor: every busy cycle is one DUT response to compare.
    always @(negedge clock) begin
        if (notReset === 1'b1 && busy === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_busy: got %h expected none", actual());
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, actual(), e.v);
            end
        end
    end

    task automatic issue(input logic [1:0] cls, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c);
        @(posedge clock); #1;
        start = 1'b1; opClass = cls; op0 = a; op1 = b; op2 = c;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock); #2;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s_timeout: got busy=%b expected 0 within 50 cycles", name, busy);
        end
    endtask

    initial begin
        notReset = 1'b0; start = 1'b0; opClass = '0; op0 = '0; op1 = '0; op2 = '0; stall = 1'b0;
        #2;
        check("reset_state", actual(), '0);
        #10 notReset = 1'b1;

        // MOV op0=1 op1=3
        push("mov_m1",  mk(1,0,0, 1,2'd2,1,1, 3'd0,3'd0, 0,0,0, 3'd1,3'd3,3'd0));
        push("mov_fin", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd1,3'd3,3'd0));
        issue(2'd0, 3'd1, 3'd3, 3'd0);
        wait_idle("mov");

        // ALU op0=1 op1=3 op2=7
        push("alu_a1",  mk(1,0,0, 1,2'd2,0,0, 3'd0,3'd0, 1,0,0, 3'd1,3'd3,3'd7));
        push("alu_a2",  mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,1,0, 3'd1,3'd3,3'd7));
        push("alu_a3",  mk(1,0,0, 0,2'd0,1,1, 3'd0,3'd0, 0,0,1, 3'd1,3'd3,3'd7));
        push("alu_fin", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd1,3'd3,3'd7));
        issue(2'd1, 3'd1, 3'd3, 3'd7);
        wait_idle("alu");

        // SWAP op0=2 op1=5
        push("swap_s1",  mk(1,0,0, 1,2'd1,1,0, 3'd0,3'd7, 0,0,0, 3'd2,3'd5,3'd0));
        push("swap_s2",  mk(1,0,0, 1,2'd2,1,1, 3'd0,3'd0, 0,0,0, 3'd2,3'd5,3'd0));
        push("swap_s3",  mk(1,0,0, 1,2'd0,1,0, 3'd7,3'd5, 0,0,0, 3'd2,3'd5,3'd0));
        push("swap_fin", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd2,3'd5,3'd0));
        issue(2'd2, 3'd2, 3'd5, 3'd0);
        wait_idle("swap");

        // ALU with 2-cycle stall in A2: busy 6 cycles
        push("stl_a1",   mk(1,0,0, 1,2'd2,0,0, 3'd0,3'd0, 1,0,0, 3'd4,3'd2,3'd6));
        push("stl_a2h0", mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,0,0, 3'd4,3'd2,3'd6));
        push("stl_a2h1", mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,0,0, 3'd4,3'd2,3'd6));
        push("stl_a2",   mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,1,0, 3'd4,3'd2,3'd6));
        push("stl_a3",   mk(1,0,0, 0,2'd0,1,1, 3'd0,3'd0, 0,0,1, 3'd4,3'd2,3'd6));
        push("stl_fin",  mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd4,3'd2,3'd6));
        issue(2'd1, 3'd4, 3'd2, 3'd6);
        @(posedge clock); #1 stall = 1'b1;
        @(posedge clock);
        @(posedge clock); #1 stall = 1'b0;
        wait_idle("stall");

        // Reserved class: single FIN cycle with err
        push("rsv_fin", mk(1,1,1, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd1,3'd2,3'd3));
        issue(2'd3, 3'd1, 3'd2, 3'd3);
        wait_idle("rsv");

        // start held through MOV: ignored until IDLE, then re-accepted
        push("hold_m1a",  mk(1,0,0, 1,2'd2,1,1, 3'd0,3'd0, 0,0,0, 3'd6,3'd1,3'd0));
        push("hold_fina", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd6,3'd1,3'd0));
        push("hold_m1b",  mk(1,0,0, 1,2'd2,1,1, 3'd0,3'd0, 0,0,0, 3'd6,3'd1,3'd0));
        push("hold_finb", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd6,3'd1,3'd0));
        @(posedge clock); #1;
        start = 1'b1; opClass = 2'd0; op0 = 3'd6; op1 = 3'd1; op2 = 3'd0;
        repeat (4) @(posedge clock);
        #1 start = 1'b0;
        wait_idle("hold");

        // Reset while in A2
        push("rst_a1", mk(1,0,0, 1,2'd2,0,0, 3'd0,3'd0, 1,0,0, 3'd5,3'd3,3'd1));
        push("rst_a2", mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,1,0, 3'd5,3'd3,3'd1));
        issue(2'd1, 3'd5, 3'd3, 3'd1);
        @(posedge clock);
        @(negedge clock); #1 notReset = 1'b0;
        #1 check("reset_mid_alu", actual(), '0);
        @(posedge clock); #1;
        check("reset_held", actual(), '0);
        @(negedge clock); #1 notReset = 1'b1;

        // Clean ALU after reset
        push("post_a1",  mk(1,0,0, 1,2'd2,0,0, 3'd0,3'd0, 1,0,0, 3'd0,3'd6,3'd2));
        push("post_a2",  mk(1,0,0, 1,2'd3,0,0, 3'd0,3'd0, 0,1,0, 3'd0,3'd6,3'd2));
        push("post_a3",  mk(1,0,0, 0,2'd0,1,1, 3'd0,3'd0, 0,0,1, 3'd0,3'd6,3'd2));
        push("post_fin", mk(1,1,0, 0,2'd0,0,0, 3'd0,3'd0, 0,0,0, 3'd0,3'd6,3'd2));
        issue(2'd1, 3'd0, 3'd6, 3'd2);
        wait_idle("post");

        repeat (3) @(negedge clock);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regsel_seq.md
Name: regsel_seq

Overview:
- Micro-sequencer that drives the regSel register-select decoder for multi-cycle register-transfer instructions (MOV, ALU, SWAP).
- Latches opClass and op0/op1/op2 on start, then steps regSel's oe/load controls and the ALU operand-latch strobes through a fixed per-class schedule.
- Sits between the instruction decoder and regSel; regSel decodes this block's outputs into regOes / regNotLoads.

Parameters:
- TMP_REG, 7, register index used as scratch by SWAP (driven on useqRegSelOe/useqRegSelLoad).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- notReset  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- opClass  in  2  00 MOV, 01 ALU, 10 SWAP, 11 reserved.
- op0  in  3  destination / first operand register index.
- op1  in  3  source A register index.
- op2  in  3  source B register index.
- stall  in  1  freeze sequencing this cycle.
- oe  out  1  to regSel oe.
- load  out  1  to regSel load.
- oeSourceSel  out  2  to regSel: 0 useq, 1 op0, 2 op1, 3 op2.
- loadSourceSel  out  1  to regSel: 0 useq, 1 op0.
- useqRegSelOe  out  3  to regSel.
- useqRegSelLoad  out  3  to regSel.
- opOut0, opOut1, opOut2  out  3 each  latched operands, fed to regSel op0/op1/op2.
- aluALoad  out  1  ALU A-operand latch strobe.
- aluBLoad  out  1  ALU B-operand latch strobe.
- aluOe  out  1  ALU result onto bus.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, reserved opClass.

Behaviour:
- Reset (async, notReset=0): state IDLE. Every output 0, including latched operands and oeSourceSel/loadSourceSel. regSel therefore sees oe=0, load=0 (regOes=00, regNotLoads=FF). Reset mid-sequence aborts with no further load; done and err stay low.
- IDLE: start=1 latches opClass, op0, op1, op2 (into opOut0/1/2) and moves to the first state of the class. start is ignored in every other state.
- Outputs are Moore decodes of state and latched fields. Any control not listed for a state is 0.
- MOV: M1: oe=1, oeSourceSel=2, load=1, loadSourceSel=1 (op0 <= op1). Then FIN.
- ALU:
  - A1: oe=1, oeSourceSel=2, aluALoad=1.
  - A2: oe=1, oeSourceSel=3, aluBLoad=1.
  - A3: aluOe=1, load=1, loadSourceSel=1.
  - Then FIN.
- SWAP:
  - S1: oe=1, oeSourceSel=1, load=1, loadSourceSel=0, useqRegSelLoad=TMP_REG.
  - S2: oe=1, oeSourceSel=2, load=1, loadSourceSel=1.
  - S3: oe=1, oeSourceSel=0, useqRegSelOe=TMP_REG, load=1, loadSourceSel=0, useqRegSelLoad=opOut1.
  - Then FIN.
- Reserved class (11): go to FIN directly with no transfers; err=1 in FIN.
- FIN: busy=1, done=1, oe=0, load=0. Next state IDLE unconditionally.
- Result: busy is high for N transfer cycles + 1 (MOV 2, ALU 4, SWAP 4, reserved 1). done is high exactly one cycle.
- stall=1 in any non-IDLE, non-FIN state:
  - State and oe-side outputs are held.
  - load, aluALoad and aluBLoad are forced 0, so no duplicate write occurs.
  - The held state re-executes fully on the first non-stall cycle.
- stall is ignored in IDLE and FIN.
- Operand fields equal (e.g. op0=op1): no special case; the schedule runs unchanged.
- Back-to-back: start is accepted the cycle after FIN (IDLE), giving a 1-cycle minimum gap between operations.

Test Plan:
- Reset pulse mid-ALU (in A2) -> outputs 0 immediately, state IDLE. Next start runs a clean sequence.
- MOV op0=1, op1=3, start -> M1: oe=1, oeSourceSel=2, load=1, loadSourceSel=1 (regSel regOes=08, regNotLoads=FD). Next cycle done=1. busy high 2 cycles.
- ALU op0=1, op1=3, op2=7 -> A1 regOes=08 with aluALoad; A2 regOes=80 with aluBLoad; A3 aluOe=1, regNotLoads=FD; then done.
- SWAP op0=2, op1=5 -> S1 regOes=04, regNotLoads=7F; S2 regOes=20, regNotLoads=FB; S3 regOes=80, regNotLoads=DF; then done.
- ALU with stall=1 for 2 cycles during A2 -> regOes=80 held, aluBLoad=0 while stalled, aluBLoad=1 for one cycle after release; total busy 6 cycles.
- Reserved opClass=3 -> one cycle with busy=1, done=1, err=1; no oe/load asserted. start held high during a MOV is ignored until IDLE.
